serial_adder: RTL and testbench

Parametrised bit-serial adder/subtractor: the sequential successor to the single-bit full-adder cell. It reuses one full-adder slice plus a carry flip-flop to add or subtract two WIDTH-bit operands one bit per clock, LSB first, under a start/busy/done handshake. It sits in the datapath wherever area matters more than latency, and it also serves as the shared arithmetic core for later multi-cycle blocks (serial multiplier, accumulator).

---
 rtl/serial_adder_if.sv | 27 ++
 rtl/serial_adder.sv | 111 +++++++++++
 tb/tb_serial_adder.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// serial_adder_if: handshake and data bundle for the bit-serial adder/subtractor.
//   master: drives start, a, b, c_in, sub; observes busy, done, sum, c_out, ovf.
//   slave : the adder side of the same signals.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  modport master (
    output start, a, b, c_in, sub,
    input  busy, done, sum, c_out, ovf
  );

  modport slave (
    input  start, a, b, c_in, sub,
    output busy, done, sum, c_out, ovf
  );
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder/subtractor, one bit per clock, LSB first.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus_io : slave side of serial_adder_if
//            start/a/b/c_in/sub captured on the accepting edge (IDLE or DONE with start=1)
//            busy while bits are processed, done one-cycle pulse when results load
//            sum/c_out/ovf hold the last completed result
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus_io
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  op_a_q, op_a_d;
  logic [WIDTH-1:0]  op_b_q, op_b_d;
  logic              carry_q, carry_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              c_out_q, c_out_d;
  logic              ovf_q, ovf_d;

  logic bit_a, bit_b, bit_s, bit_c;

  // Single full-adder slice on the current bit.
  always_comb begin
    bit_a = op_a_q[cnt_q];
    bit_b = op_b_q[cnt_q];
    bit_s = bit_a ^ bit_b ^ carry_q;
    bit_c = (bit_a & bit_b) | (bit_a & carry_q) | (bit_b & carry_q);
  end

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (bus_io.start) begin
          state_d = StRun;
          op_a_d  = bus_io.a;
          // Subtraction as A + ~B + ~borrow_in.
          op_b_d  = bus_io.sub ? ~bus_io.b : bus_io.b;
          carry_d = bus_io.c_in ^ bus_io.sub;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      StRun: begin
        carry_d = bit_c;
        shift_d = {bit_s, shift_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StDone;
          cnt_d   = cnt_q;
          sum_d   = {bit_s, shift_q[WIDTH-1:1]};
          c_out_d = bit_c;
          // carry_q is the carry into the MSB on this edge.
          ovf_d   = carry_q ^ bit_c;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_a_q  <= '0;
      op_b_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      shift_q <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus_io.busy  = (state_q == StRun);
  assign bus_io.done  = (state_q == StDone);
  assign bus_io.sum   = sum_q;
  assign bus_io.c_out = c_out_q;
  assign bus_io.ovf   = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed checks of serial_adder at WIDTH=8 plus an exhaustive
// sweep of a WIDTH=4 instance against a word-level arithmetic model.
module tb_serial_adder;

  logic clk;
  logic rst_n;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(4)) bus4 ();

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus8)
  );

  serial_adder #(.WIDTH(4)) u_dut4 (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Last expected {sum, c_out, ovf} of the 8-bit instance; must hold during a run.
  logic [9:0] prev8 = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic sub);
    bus8.start = 1'b1;
    bus8.a     = a;
    bus8.b     = b;
    bus8.c_in  = cin;
    bus8.sub   = sub;
  endtask

  // Takes the accepting edge, then follows the run until done (bounded).
  task automatic finish8(input string tag, input logic [7:0] es, input logic ec,
                         input logic eo, input bit poke);
    int n;
    int nbusy;
    bit stable;
    @(posedge clk); #1;
    // Scramble inputs: the operation in flight must not see them.
    bus8.start = 1'b0;
    bus8.a     = 8'hA5;
    bus8.b     = 8'h5A;
    bus8.c_in  = ~bus8.c_in;
    bus8.sub   = ~bus8.sub;
    n      = 0;
    nbusy  = 0;
    stable = 1'b1;
    check_eq({tag, "_done_at_accept"}, 32'(bus8.done), 32'd0);
    while (!bus8.done && n < 24) begin
      if (bus8.busy) nbusy++;
      if ({bus8.sum, bus8.c_out, bus8.ovf} !== prev8) stable = 1'b0;
      if (poke && n == 2) begin
        bus8.start = 1'b1;
        bus8.a     = 8'hFF;
        bus8.b     = 8'hFF;
      end
      @(posedge clk); #1;
      n++;
      if (poke && n == 3) bus8.start = 1'b0;
    end
    check_eq({tag, "_latency"}, 32'(n), 32'd8);
    check_eq({tag, "_busy_cycles"}, 32'(nbusy), 32'd8);
    check_eq({tag, "_busy_at_done"}, 32'(bus8.busy), 32'd0);
    check_eq({tag, "_hold"}, 32'(stable), 32'd1);
    check_eq({tag, "_sum"}, 32'(bus8.sum), 32'(es));
    check_eq({tag, "_cout"}, 32'(bus8.c_out), 32'(ec));
    check_eq({tag, "_ovf"}, 32'(bus8.ovf), 32'(eo));
    prev8 = {es, ec, eo};
  endtask

  // One idle edge after done: the pulse must be gone and nothing restarted.
  task automatic idle8(input string tag);
    @(posedge clk); #1;
    check_eq({tag, "_done_pulse"}, 32'(bus8.done), 32'd0);
    check_eq({tag, "_idle_busy"}, 32'(bus8.busy), 32'd0);
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic cin, input logic sub, input logic [7:0] es,
                     input logic ec, input logic eo);
    start8(a, b, cin, sub);
    finish8(tag, es, ec, eo, 1'b0);
    idle8(tag);
  endtask

  // Word-level reference for the 4-bit instance: {sum, c_out, ovf}.
  function automatic logic [5:0] model4(input logic [3:0] a, input logic [3:0] b,
                                        input logic cin, input logic sub);
    logic [4:0] full;
    logic       ov;
    if (!sub) begin
      full = {1'b0, a} + {1'b0, b} + {4'b0, cin};
      ov   = (a[3] == b[3]) && (full[3] != a[3]);
    end else begin
      full = {1'b0, a} + {1'b0, ~b} + {4'b0, ~cin};
      ov   = (a[3] != b[3]) && (full[3] != a[3]);
    end
    return {full[3:0], full[4], ov};
  endfunction

  initial begin
    rst_n      = 1'b0;
    bus8.start = 1'b0;
    bus8.a     = '0;
    bus8.b     = '0;
    bus8.c_in  = 1'b0;
    bus8.sub   = 1'b0;
    bus4.start = 1'b0;
    bus4.a     = '0;
    bus4.b     = '0;
    bus4.c_in  = 1'b0;
    bus4.sub   = 1'b0;

    #12;
    check_eq("reset_outputs", 32'({bus8.busy, bus8.done, bus8.sum, bus8.c_out, bus8.ovf}), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("idle_after_reset", 32'({bus8.busy, bus8.done}), 32'd0);

    op8("add_0f_01", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
    op8("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    op8("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    op8("add_cin",   8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0);
    op8("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    op8("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    op8("sub_borrow", 8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b1, 1'b0);

    // start pulsed at edge k+3 with other operands: must be ignored.
    start8(8'h21, 8'h13, 1'b0, 1'b0);
    finish8("ignore_start", 8'h34, 1'b0, 1'b0, 1'b1);
    idle8("ignore_start");

    // Back-to-back: start held through the DONE cycle.
    start8(8'h40, 8'h40, 1'b0, 1'b0);
    finish8("b2b_first", 8'h80, 1'b0, 1'b1, 1'b0);
    start8(8'h03, 8'h01, 1'b0, 1'b1);
    finish8("b2b_second", 8'h02, 1'b1, 1'b0, 1'b0);
    idle8("b2b_second");

    // Reset in the middle of a run: abandoned, outputs cleared, no done.
    start8(8'h11, 8'h22, 1'b0, 1'b0);
    @(posedge clk); #1;
    bus8.start = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_eq("midrun_reset_outputs",
             32'({bus8.busy, bus8.done, bus8.sum, bus8.c_out, bus8.ovf}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("midrun_reset_no_done", 32'({bus8.busy, bus8.done}), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    prev8 = '0;
    @(posedge clk); #1;
    op8("after_reset", 8'h33, 8'h44, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0);

    // Exhaustive WIDTH=4 sweep, chaining each start into the DONE cycle.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          for (int is = 0; is < 2; is++) begin
            int n;
            bus4.start = 1'b1;
            bus4.a     = 4'(ia);
            bus4.b     = 4'(ib);
            bus4.c_in  = 1'(ic);
            bus4.sub   = 1'(is);
            @(posedge clk); #1;
            bus4.start = 1'b0;
            n = 0;
            while (!bus4.done && n < 12) begin
              @(posedge clk); #1;
              n++;
            end
            check_eq($sformatf("w4_a%0d_b%0d_c%0d_s%0d", ia, ib, ic, is),
                     32'({bus4.sum, bus4.c_out, bus4.ovf, n[3:0]}),
                     32'({model4(4'(ia), 4'(ib), 1'(ic), 1'(is)), 4'd4}));
          end
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
